// File: rtl/spike_time_scheduler_pkg.sv
// Shared definitions for the spike time scheduler: window length default and FSM states.
`ifndef TIME_PERIOD_DFLT
`define TIME_PERIOD_DFLT 8
`endif

package spike_time_scheduler_pkg;

  localparam int unsigned TIME_PERIOD_DEFAULT = `TIME_PERIOD_DFLT;

  // Counter width; never below 1 so degenerate windows still elaborate.
  function automatic int unsigned tw_of(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/spike_time_scheduler_spike_generation.sv
// Per-channel spike decision: fires while the current time step is below the programmed time.
module spike_generation #(
  parameter int unsigned TW = 3
) (
  input  logic          should_spike_i,
  input  logic [TW-1:0] spike_time_i,
  input  logic [TW-1:0] time_val_i,
  output logic          spike_o
);

  assign spike_o = should_spike_i && (spike_time_i > time_val_i);

endmodule

// File: rtl/spike_time_scheduler.sv
// Accepts one sample of per-channel spike times and replays it as TIME_PERIOD output beats.
module spike_time_scheduler
  import spike_time_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS  = 4,
  parameter  int unsigned TIME_PERIOD = TIME_PERIOD_DEFAULT,
  localparam int unsigned TW          = tw_of(TIME_PERIOD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_INPUTS-1:0]    in_should_spike,
  input  logic [NUM_INPUTS*TW-1:0] in_spike_time,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TW-1:0]            out_time,
  output logic [NUM_INPUTS-1:0]    out_spikes,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [TW-1:0] LAST_STEP = TW'(TIME_PERIOD - 1);

  sched_state_t                state_q, state_d;
  logic [TW-1:0]               cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0]       ss_q, ss_d;
  logic [NUM_INPUTS*TW-1:0]    st_q, st_d;
  logic [NUM_INPUTS-1:0]       spikes_raw;
  logic                        run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ss_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ss_q    <= ss_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ss_d      = ss_q;
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ss_d    = in_should_spike;
          st_d    = in_spike_time;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // Wrap on the window length, not the counter's natural range.
        if (out_ready) begin
          if (cnt_q == LAST_STEP) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    spike_generation #(
      .TW(TW)
    ) u_spike_generation (
      .should_spike_i (ss_q[i]),
      .spike_time_i   (st_q[i*TW +: TW]),
      .time_val_i     (cnt_q),
      .spike_o        (spikes_raw[i])
    );
  end

  assign run        = (state_q == RUN);
  assign out_time   = run ? cnt_q : '0;
  assign out_spikes = run ? spikes_raw : '0;
  assign out_last   = run && (cnt_q == LAST_STEP);

endmodule

// File: tb/tb_spike_time_scheduler.sv
// Self-checking bench: window table, scoreboard of expected beats, reset and short-window sequences.
module tb_spike_time_scheduler;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int TW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_ready;
  logic [N-1:0]    in_ss;
  logic [N*TW-1:0] in_st;
  logic            out_valid, out_ready;
  logic [TW-1:0]   out_time;
  logic [N-1:0]    out_spikes;
  logic            out_last, busy;

  logic            v6, r6, ov6, ordy6, ol6, busy6;
  logic [N-1:0]    ss6, sp6;
  logic [N*TW-1:0] st6;
  logic [TW-1:0]   ot6;

  spike_time_scheduler #(.NUM_INPUTS(N), .TIME_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_should_spike(in_ss), .in_spike_time(in_st), .out_valid(out_valid),
    .out_ready(out_ready), .out_time(out_time), .out_spikes(out_spikes),
    .out_last(out_last), .busy(busy)
  );

  spike_time_scheduler #(.NUM_INPUTS(N), .TIME_PERIOD(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6),
    .in_should_spike(ss6), .in_spike_time(st6), .out_valid(ov6),
    .out_ready(ordy6), .out_time(ot6), .out_spikes(sp6),
    .out_last(ol6), .busy(busy6)
  );

  typedef struct packed {
    logic [TW-1:0] t;
    logic [N-1:0]  sp;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [N-1:0]      ss;
    logic [N*TW-1:0]   st;
    logic              toggle;
    logic [N-1:0][3:0] cnt;
  } vec_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    hi_cnt[N];
  int    beats;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_window(input logic [N-1:0] ss, input logic [N*TW-1:0] st);
    beat_t b;
    for (int t = 0; t < P; t++) begin
      b.t    = TW'(t);
      b.sp   = '0;
      for (int i = 0; i < N; i++) b.sp[i] = ss[i] && (int'(st[i*TW +: TW]) > t);
      b.last = (t == P - 1);
      sb.push_back(b);
    end
  endfunction

  task automatic monitor();
    beat_t b;
    if (rst) begin
      sb.delete();
      return;
    end
    chk("in_ready", int'(in_ready), int'(sb.size() == 0));
    chk("out_valid", int'(out_valid), int'(sb.size() != 0));
    chk("busy", int'(busy), int'(sb.size() != 0));
    if (sb.size() == 0) begin
      chk("idle_time", int'(out_time), 0);
      chk("idle_spikes", int'(out_spikes), 0);
      chk("idle_last", int'(out_last), 0);
      if (in_valid) push_window(in_ss, in_st);
    end else begin
      b = sb[0];
      chk("out_time", int'(out_time), int'(b.t));
      chk("out_spikes", int'(out_spikes), int'(b.sp));
      chk("out_last", int'(out_last), int'(b.last));
      if (out_ready) begin
        void'(sb.pop_front());
        beats++;
        for (int i = 0; i < N; i++) hi_cnt[i] += int'(out_spikes[i]);
      end
    end
  endtask

  task automatic tick(input logic iv, input logic [N-1:0] ss, input logic [N*TW-1:0] st,
                      input logic ordy);
    @(negedge clk);
    rst = 1'b0; in_valid = iv; in_ss = ss; in_st = st; out_ready = ordy;
    #1 monitor();
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1 monitor();
  endtask

  task automatic run_window(input vec_t v);
    int c;
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    beats = 0;
    tick(1'b1, v.ss, v.st, 1'b1);
    c = 0;
    // In-flight input activity must not disturb the latched sample.
    while (sb.size() != 0 && c < 100) begin
      tick(1'($urandom), N'($urandom), (N*TW)'($urandom), v.toggle ? (c % 3 == 0) : 1'b1);
      c++;
    end
    chk("window_timeout", int'(c >= 100), 0);
    chk("beats", beats, P);
    for (int i = 0; i < N; i++) chk($sformatf("ch%0d_count", i), hi_cnt[i], int'(v.cnt[i]));
  endtask

  vec_t vt[5];
  int   c;

  initial begin
    vt[0] = '{4'b1111, {3'd7, 3'd4, 3'd1, 3'd0}, 1'b0, {4'd7, 4'd4, 4'd1, 4'd0}};
    vt[1] = '{4'b0101, {3'd7, 3'd7, 3'd7, 3'd7}, 1'b0, {4'd0, 4'd7, 4'd0, 4'd7}};
    vt[2] = '{4'b1111, {3'd7, 3'd4, 3'd1, 3'd0}, 1'b1, {4'd7, 4'd4, 4'd1, 4'd0}};
    vt[3] = '{4'b1010, {3'd2, 3'd5, 3'd0, 3'd3}, 1'b0, {4'd2, 4'd0, 4'd0, 4'd0}};
    vt[4] = '{4'b1111, {3'd2, 3'd3, 3'd5, 3'd6}, 1'b1, {4'd2, 4'd3, 4'd5, 4'd6}};

    rst = 1'b1; in_valid = 1'b0; in_ss = '0; in_st = '0; out_ready = 1'b1;
    v6 = 1'b0; ss6 = '0; st6 = '0; ordy6 = 1'b1;
    reset_cycle();
    reset_cycle();
    tick(1'b0, '0, '0, 1'b1);

    for (int k = 0; k < 5; k++) run_window(vt[k]);
    tick(1'b0, '0, '0, 1'b1);

    // Continuous offers: next sample must be taken right after the last beat.
    for (int k = 0; k < 3 * (P + 1); k++) tick(1'b1, N'($urandom), (N*TW)'($urandom), 1'b1);
    c = 0;
    while (sb.size() != 0 && c < 50) begin
      tick(1'b0, '0, '0, 1'b1);
      c++;
    end
    chk("drain_timeout", int'(c >= 50), 0);

    // Reset in the middle of a window.
    tick(1'b1, 4'b1111, {4{3'd7}}, 1'b1);
    c = 0;
    while (sb.size() != 0 && sb[0].t != 3'd3 && c < 50) begin
      tick(1'b0, '0, '0, 1'b1);
      c++;
    end
    chk("reach_t3", int'(sb.size() != 0 && sb[0].t == 3'd3), 1);
    reset_cycle();
    tick(1'b0, 4'b1111, {4{3'd7}}, 1'b1);
    tick(1'b0, '0, '0, 1'b1);
    run_window(vt[0]);

    // Short window (TIME_PERIOD=6).
    @(negedge clk);
    v6 = 1'b1; ss6 = 4'b0011; st6 = {3'd0, 3'd0, 3'd7, 3'd5}; ordy6 = 1'b1;
    #1;
    chk("p6_in_ready", int'(r6), 1);
    chk("p6_idle_valid", int'(ov6), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v6 = 1'b0; ordy6 = 1'b1;
      #1;
      chk("p6_valid", int'(ov6), 1);
      chk("p6_time", int'(ot6), k);
      chk("p6_last", int'(ol6), int'(k == 5));
      chk("p6_spikes", int'(sp6), int'({2'b00, 1'b1, 1'(k < 5)}));
    end
    @(negedge clk);
    #1;
    chk("p6_done_valid", int'(ov6), 0);
    chk("p6_done_ready", int'(r6), 1);
    chk("p6_done_time", int'(ot6), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
